// File: rtl/display_timing_640x480.sv
// Raster timing generator for a 640x480 60 Hz display: position counters, syncs,
// data enable, line/frame strobes and a completed-frame counter, all registered.
module display_timing_640x480 #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   CORDW    = 10,
  parameter int   FCW      = 16
) (
  input  logic             clk_pix,
  input  logic             rst,
  input  logic             clk_pix_locked,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line,
  output logic             frame,
  output logic [FCW-1:0]   frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_ACTIVE);
  localparam logic [CORDW-1:0] HS_STA = CORDW'(H_ACTIVE + H_FP);
  localparam logic [CORDW-1:0] HS_END = CORDW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CORDW-1:0] VS_STA = CORDW'(V_ACTIVE + V_FP);
  localparam logic [CORDW-1:0] VS_END = CORDW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CORDW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic             hsync_q, vsync_q, de_q, line_q, frame_q;
  logic [FCW-1:0]   fc_q;
  logic             first_q;  // still inside the first frame after a hold
  logic             hold;

  assign hold = !rst || !clk_pix_locked;

  always_comb begin
    sx_d = (sx_q == H_LAST) ? '0 : sx_q + 1'b1;
    sy_d = sy_q;
    if (sx_q == H_LAST) sy_d = (sy_q == V_LAST) ? '0 : sy_q + 1'b1;
  end

  // Syncs/strobes decode the next-state counters so they line up with sx/sy.
  always_ff @(posedge clk_pix) begin
    if (hold) begin
      sx_q    <= H_LAST;
      sy_q    <= V_LAST;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      de_q    <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      fc_q    <= '0;
      first_q <= 1'b1;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      hsync_q <= (sx_d >= HS_STA && sx_d <= HS_END) ? H_POL : ~H_POL;
      vsync_q <= (sy_d >= VS_STA && sy_d <= VS_END) ? V_POL : ~V_POL;
      de_q    <= (sx_d < H_ACT) && (sy_d < V_ACT);
      line_q  <= (sx_d == '0);
      frame_q <= (sx_d == '0) && (sy_d == '0);
      if (sx_d == '0 && sy_d == '0) begin
        if (!first_q) fc_q <= fc_q + FCW'(1);
        first_q <= 1'b0;
      end
    end
  end

  assign sx          = sx_q;
  assign sy          = sy_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign line        = line_q;
  assign frame       = frame_q;
  assign frame_count = fc_q;

endmodule

// File: doc/display_timing_640x480.md
Name: display_timing_640x480

Overview:
- Consumer end of the pixel-clock interface: runs on `clk_pix` and is gated by `clk_pix_locked` from the 25.125 MHz clock generator.
- Produces 640x480 60 Hz raster timing: screen position, hsync, vsync, data enable, plus line/frame strobes and a frame counter.
- Feeds the game renderer and the DVI/VGA output stage.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)
- CORDW, 10, width of sx/sy
- FCW, 16, width of frame_count

Ports:
- clk_pix  in  1  pixel clock; the single clock
- rst  in  1  reset; synchronous, active-low
- clk_pix_locked  in  1  pixel clock locked; already synchronised to clk_pix
- sx  out  CORDW  horizontal position, 0..H_TOTAL-1
- sy  out  CORDW  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level per H_POL
- vsync  out  1  vertical sync, level per V_POL
- de  out  1  data enable; high in the active area
- line  out  1  one-cycle strobe at the start of each line
- frame  out  1  one-cycle strobe at the start of each frame
- frame_count  out  FCW  completed-frame counter

Behaviour:
- Totals and default values:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - HS_STA = H_ACTIVE+H_FP (656); HS_END = HS_STA+H_SYNC-1 (751).
  - VS_STA = V_ACTIVE+V_FP (490); VS_END = VS_STA+V_SYNC-1 (491).
- Hold condition: rst==0 OR clk_pix_locked==0, sampled at posedge clk_pix. A hold forces all outputs to their reset values:
  - sx=H_TOTAL-1, sy=V_TOTAL-1
  - hsync=~H_POL, vsync=~V_POL
  - de=0, line=0, frame=0, frame_count=0
- Hold values are a legal blanking position, so the first running edge lands on (0,0).
- Running, every clk_pix edge:
  - sx increments; when sx==H_TOTAL-1 it wraps to 0.
  - sy increments only when sx wraps; when sy==V_TOTAL-1 it also wraps to 0.
- Output alignment:
  - All outputs are registered and describe the sx/sy value present in the same cycle. Zero latency between position and sync/de; implement by decoding the next-state counters.
  - hsync = H_POL when HS_STA<=sx<=HS_END, else ~H_POL.
  - vsync = V_POL when VS_STA<=sy<=VS_END, else ~V_POL. vsync changes only in cycles where sx==0.
  - de = (sx<H_ACTIVE) && (sy<V_ACTIVE).
  - line = (sx==0). frame = (sx==0 && sy==0).
- frame_count:
  - Increments by 1 in the cycle frame rises, except the first frame after a hold. It counts completed frames, so it reads 0 during the first frame.
  - Wraps modulo 2^FCW with no saturation.
- Lock loss or reset mid-frame: takes effect on the next edge, with no completion of the line. On release, timing restarts at (0,0) with frame=1 in the first running cycle.
- No combinational path from any input to any output.

Test Plan:
- Reset release: rst low 5 cycles, locked=1 -> outputs sx=799, sy=524, de=0, hsync=vsync=1, frame_count=0. One edge after rst goes high -> sx=0, sy=0, de=1, line=1, frame=1, frame_count=0.
- Horizontal line check: run 800 cycles from (0,0).
  - de=1 for sx 0..639, 0 otherwise; hsync=0 exactly for sx 656..751 (96 cycles).
  - line pulses at cycle 800, with sx=0 and sy=1.
- Vertical frame check: run 420000 cycles.
  - vsync=0 exactly for sy 490..491, i.e. 1600 cycles starting at sx=0, sy=490.
  - de never 1 for sy>=480.
  - A second frame strobe occurs at cycle 420000 with frame_count=1.
- Lock loss mid-frame: drop clk_pix_locked at sx=300, sy=200 for 3 cycles.
  - Next edge: sx=799, sy=524, de=0, frame_count=0.
  - On re-lock: restart at (0,0) with frame=1.
- Counter wrap: FCW=2 build, run 5 frames.
  - frame_count sequence 0,1,2,3,0.
  - Each value lasts exactly 420000 cycles.
- Parameter variant: H_POL=1, V_POL=1 -> hsync=1 only for sx 656..751, vsync=1 only for sy 490..491. Reset values are hsync=vsync=0.
